// File: rtl/ru_allocator_os.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ru_allocator_os: row-major binding of faulty PEs to redundant units.       |
// | Optional macro FAULT_MAP_STICKY_EN keeps bindings/fault map across starts. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ru_allocator_os #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int NUM_RU        = 4,
  parameter int NUM_BITS_COLS = $clog2(COLS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alloc_start,
  input  logic [ROWS*COLS-1:0]            STW_result_mat,
  output logic                            alloc_busy,
  output logic                            alloc_done,
  output logic [NUM_RU-1:0]               ru_en,
  output logic [NUM_BITS_COLS*NUM_RU-1:0] ru_row_mapping,
  output logic [NUM_BITS_COLS*NUM_RU-1:0] ru_col_mapping,
  output logic [$clog2(ROWS*COLS+1)-1:0]  fault_count,
  output logic                            alloc_overflow
);

  localparam int NUM_PE = ROWS * COLS;
  localparam int IDX_W  = $clog2(NUM_PE);
  localparam int FC_W   = $clog2(NUM_PE + 1);
  localparam int RU_W   = $clog2(NUM_RU + 1);
  localparam int NB     = NUM_BITS_COLS;
  localparam logic [RU_W-1:0]  RU_MAX   = RU_W'(NUM_RU);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_PE-1:0]      acc_map_q, acc_map_d;
  logic [NUM_PE-1:0]      alloc_mask_q, alloc_mask_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [RU_W-1:0]        next_ru_q, next_ru_d;
  logic [NUM_RU-1:0]      ru_en_q, ru_en_d;
  logic [NB*NUM_RU-1:0]   ru_row_q, ru_row_d;
  logic [NB*NUM_RU-1:0]   ru_col_q, ru_col_d;
  logic [FC_W-1:0]        fault_count_q, fault_count_d;
  logic                   overflow_q, overflow_d;

  logic [NB-1:0]          w_row;
  logic [NB-1:0]          w_col;
  logic                   w_fault;
  logic                   w_unbound;

  assign w_row     = NB'(int'(idx_q) / COLS);
  assign w_col     = NB'(int'(idx_q) % COLS);
  assign w_fault   = acc_map_q[idx_q];
  assign w_unbound = w_fault && !alloc_mask_q[idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_map_q     <= '0;
      alloc_mask_q  <= '0;
      idx_q         <= '0;
      next_ru_q     <= '0;
      ru_en_q       <= '0;
      ru_row_q      <= '0;
      ru_col_q      <= '0;
      fault_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_map_q     <= acc_map_d;
      alloc_mask_q  <= alloc_mask_d;
      idx_q         <= idx_d;
      next_ru_q     <= next_ru_d;
      ru_en_q       <= ru_en_d;
      ru_row_q      <= ru_row_d;
      ru_col_q      <= ru_col_d;
      fault_count_q <= fault_count_d;
      overflow_q    <= overflow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_map_d     = acc_map_q;
    alloc_mask_d  = alloc_mask_q;
    idx_d         = idx_q;
    next_ru_d     = next_ru_q;
    ru_en_d       = ru_en_q;
    ru_row_d      = ru_row_q;
    ru_col_d      = ru_col_q;
    fault_count_d = fault_count_q;
    overflow_d    = overflow_q;

    case (state_q)
      IDLE: begin
        if (alloc_start) begin
`ifdef FAULT_MAP_STICKY_EN
          // Existing bindings stay put; only new faults consume free RUs.
          acc_map_d    = acc_map_q | STW_result_mat;
`else
          acc_map_d    = STW_result_mat;
          alloc_mask_d = '0;
          next_ru_d    = '0;
          ru_en_d      = '0;
          ru_row_d     = '0;
          ru_col_d     = '0;
`endif
          idx_d         = '0;
          fault_count_d = '0;
          overflow_d    = 1'b0;
          state_d       = SCAN;
        end
      end

      SCAN: begin
        if (w_fault) begin
          fault_count_d = fault_count_q + FC_W'(1);
        end
        if (w_unbound) begin
          if (next_ru_q < RU_MAX) begin
            for (int i = 0; i < NUM_RU; i++) begin
              if (next_ru_q == RU_W'(i)) begin
                ru_en_d[i]             = 1'b1;
                ru_row_d[i*NB +: NB]   = w_row;
                ru_col_d[i*NB +: NB]   = w_col;
              end
            end
            alloc_mask_d[idx_q] = 1'b1;
            next_ru_d           = next_ru_q + RU_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign alloc_busy     = (state_q == SCAN);
  assign alloc_done     = (state_q == DONE);
  assign ru_en          = ru_en_q;
  assign ru_row_mapping = ru_row_q;
  assign ru_col_mapping = ru_col_q;
  assign fault_count    = fault_count_q;
  assign alloc_overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ru_allocator_os.sv
`default_nettype none
// Bench for ru_allocator_os: directed scenarios plus random maps checked
// every cycle against a whole-scan behavioural model.
module tb_ru_allocator_os;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int NUM_RU = 4;
  localparam int NB     = $clog2(COLS);
  localparam int N      = ROWS * COLS;
  localparam int FCW    = $clog2(N + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 alloc_start;
  logic [N-1:0]         map;
  logic                 alloc_busy, alloc_done, alloc_overflow;
  logic [NUM_RU-1:0]    ru_en;
  logic [NB*NUM_RU-1:0] ru_row_mapping, ru_col_mapping;
  logic [FCW-1:0]       fault_count;

  ru_allocator_os #(.ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU)) dut (
    .clk(clk), .rst(rst), .alloc_start(alloc_start), .STW_result_mat(map),
    .alloc_busy(alloc_busy), .alloc_done(alloc_done), .ru_en(ru_en),
    .ru_row_mapping(ru_row_mapping), .ru_col_mapping(ru_col_mapping),
    .fault_count(fault_count), .alloc_overflow(alloc_overflow)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 scan, 2 done. Final results are computed at start.
  int                   m_phase = 0;
  int                   m_cnt = 0;
  int                   m_nb = 0;
  int                   m_bidx [NUM_RU];
  logic [N-1:0]         m_acc = '0;
  logic [NUM_RU-1:0]    e_en = '0;
  logic [NB*NUM_RU-1:0] e_row = '0, e_col = '0;
  int                   e_fc = 0;
  logic                 e_ovf = 1'b0;
  logic                 s_rst, s_start;
  logic [N-1:0]         s_map;

  task automatic model_step();
    bit bound;
    if (s_rst) begin
      m_phase = 0; m_nb = 0; m_acc = '0;
      e_en = '0; e_row = '0; e_col = '0; e_fc = 0; e_ovf = 1'b0;
    end else if (m_phase == 0) begin
      if (s_start) begin
`ifdef FAULT_MAP_STICKY_EN
        m_acc = m_acc | s_map;
`else
        m_acc = s_map;
        m_nb  = 0;
`endif
        e_fc  = $countones(m_acc);
        e_ovf = 1'b0;
        for (int p = 0; p < N; p++) begin
          if (m_acc[p]) begin
            bound = 1'b0;
            for (int j = 0; j < m_nb; j++) if (m_bidx[j] == p) bound = 1'b1;
            if (!bound) begin
              if (m_nb < NUM_RU) begin
                m_bidx[m_nb] = p;
                m_nb++;
              end else e_ovf = 1'b1;
            end
          end
        end
        e_en = '0; e_row = '0; e_col = '0;
        for (int j = 0; j < m_nb; j++) begin
          e_en[j]            = 1'b1;
          e_row[j*NB +: NB]  = NB'(m_bidx[j] / COLS);
          e_col[j*NB +: NB]  = NB'(m_bidx[j] % COLS);
        end
        m_phase = 1; m_cnt = 1;
      end
    end else if (m_phase == 1) begin
      if (m_cnt == N) m_phase = 2;
      else m_cnt++;
    end else begin
      m_phase = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst; s_start = alloc_start; s_map = map;
      @(negedge clk);
      model_step();
      chk("busy", 32'(alloc_busy), 32'(m_phase == 1));
      chk("done", 32'(alloc_done), 32'(m_phase == 2));
      if (m_phase != 1) begin
        chk("ru_en", 32'(ru_en), 32'(e_en));
        chk("row_map", 32'(ru_row_mapping), 32'(e_row));
        chk("col_map", 32'(ru_col_mapping), 32'(e_col));
        chk("fault_count", 32'(fault_count), 32'(e_fc));
        chk("overflow", 32'(alloc_overflow), 32'(e_ovf));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // mode 0 normal, 1 second start mid-scan, 2 reset mid-scan
  task automatic run(input logic [N-1:0] m, input int mode);
    int lat, dn;
    @(negedge clk); alloc_start = 1'b1; map = m;
    @(negedge clk); alloc_start = 1'b0; map = N'($urandom); lat = 1;
    if (mode == 2) begin
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("midrst_busy", 32'(alloc_busy), 0);
      chk("midrst_en", 32'(ru_en), 0);
      chk("midrst_fc", 32'(fault_count), 0);
      dn = 0;
      repeat (25) begin
        @(negedge clk);
        if (alloc_done) dn++;
      end
      chk("midrst_no_done", 32'(dn), 0);
    end else begin
      while (!alloc_done && lat < 40) begin
        alloc_start = (mode == 1 && lat == 5);
        if (alloc_start) map = ~m;
        @(negedge clk); lat++;
      end
      alloc_start = 1'b0;
      chk("latency", 32'(lat), 32'(N + 1));
      chk("busy_at_done", 32'(alloc_busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1; alloc_start = 1'b0; map = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(alloc_busy), 0);
    chk("rst_en", 32'(ru_en), 0);
    chk("rst_fc", 32'(fault_count), 0);
    alloc_start = 1'b1; map = '1;
    @(negedge clk); alloc_start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 32'(alloc_busy), 0);

    do_reset();
    run(16'h0802, 0);
    chk("s1_en", 32'(ru_en), 32'h3);
    chk("s1_row", 32'(ru_row_mapping), 32'h08);
    chk("s1_col", 32'(ru_col_mapping), 32'h0D);
    chk("s1_fc", 32'(fault_count), 2);
    chk("s1_ovf", 32'(alloc_overflow), 0);

    do_reset();
    run(16'h8429, 0);
    chk("s2_en", 32'(ru_en), 32'hF);
    chk("s2_row", 32'(ru_row_mapping), 32'h90);
    chk("s2_col", 32'(ru_col_mapping), 32'h9C);
    chk("s2_fc", 32'(fault_count), 5);
    chk("s2_ovf", 32'(alloc_overflow), 1);

    do_reset();
    run(16'h0802, 1);
    chk("s3_en", 32'(ru_en), 32'h3);
    chk("s3_row", 32'(ru_row_mapping), 32'h08);
    chk("s3_col", 32'(ru_col_mapping), 32'h0D);

    do_reset();
    run(16'h8429, 2);

    do_reset();
    run(16'h8000, 0);
    run(16'h0001, 0);
`ifdef FAULT_MAP_STICKY_EN
    chk("s5_en", 32'(ru_en), 32'h3);
    chk("s5_row", 32'(ru_row_mapping), 32'h03);
    chk("s5_col", 32'(ru_col_mapping), 32'h03);
    chk("s5_fc", 32'(fault_count), 2);
`else
    chk("s5_en", 32'(ru_en), 32'h1);
    chk("s5_row", 32'(ru_row_mapping), 32'h00);
    chk("s5_col", 32'(ru_col_mapping), 32'h00);
    chk("s5_fc", 32'(fault_count), 1);
`endif

    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] rm;
      int md;
      if ($urandom_range(0, 7) == 0) do_reset();
      rm = ($urandom_range(0, 2) == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      md = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 14) == 0) ? 2 : 0);
      run(rm, md);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
